// File: rtl/mem_walk_fsm.sv
// mem_walk_fsm: walks WORDS consecutive RAM words from address 0. Each word is read,
// optionally written back incremented, and held on the 16-bit display bus for
// HOLD_CYCLES cycles.
// Build option: define MEM_WALK_WRITEBACK_EN to enable the increment write-back; otherwise
// the RAM is only read and the raw value is displayed.
module mem_walk_fsm #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned WORDS       = 16,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_d,
  output logic [15:0]           disp_value,
  output logic                  disp_valid,
  output logic                  busy,
  output logic                  done
);

`ifdef MEM_WALK_WRITEBACK_EN
  localparam bit WbEn = 1'b1;
`else
  localparam bit WbEn = 1'b0;
`endif

  localparam int unsigned         HoldW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HoldW-1:0]      HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_WIDTH-1:0] AddrLast = ADDR_WIDTH'(WORDS - 1);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StShow, StDone} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic                    mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0]   mem_d_q, mem_d_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [15:0]             disp_value_q, disp_value_d;
  logic [HoldW-1:0]        hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   data_inc;
  logic [DATA_WIDTH-1:0]   mem_q_inc;

  assign data_inc  = data_q + DATA_WIDTH'(1);
  assign mem_q_inc = mem_q + DATA_WIDTH'(1);

  // Next-state and registered-output logic for the walk sequencer.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_d_d      = mem_d_q;
    data_d       = data_q;
    disp_value_d = disp_value_q;
    hold_d       = hold_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          mem_addr_d = '0;
          state_d    = StRead;
        end
      end
      StRead: begin
        state_d = StWait;
      end
      StWait: begin
        data_d  = mem_q;
        state_d = StWrite;
        // Write strobe and data are registered, so they are set up here to be
        // on the port during the WRITE cycle; mem_q is what data_q becomes.
        if (WbEn) begin
          mem_we_d = 1'b1;
          mem_d_d  = mem_q_inc;
        end
      end
      StWrite: begin
        disp_value_d = WbEn ? 16'(data_inc) : 16'(data_q);
        hold_d       = '0;
        state_d      = StShow;
      end
      StShow: begin
        if (hold_q == HoldLast) begin
          hold_d = '0;
          if (mem_addr_q == AddrLast) begin
            state_d = StDone;
          end else begin
            mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
            state_d    = StRead;
          end
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_d_q      <= '0;
      data_q       <= '0;
      disp_value_q <= '0;
      hold_q       <= '0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_d_q      <= mem_d_d;
      data_q       <= data_d;
      disp_value_q <= disp_value_d;
      hold_q       <= hold_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_d      = mem_d_q;
  assign disp_value = disp_value_q;
  assign disp_valid = (state_q == StShow) || (state_q == StDone);
  assign busy       = (state_q != StIdle) && (state_q != StDone);
  assign done       = (state_q == StDone);

endmodule

// File: tb/tb_mem_walk_fsm.sv
// Testbench for mem_walk_fsm: small RAM model, cycle-level reference of the walk,
// table of known words, randomized RAM contents and start patterns.
module tb_mem_walk_fsm;
  localparam int NW    = 4;
  localparam int HC    = 2;
  localparam int PER   = HC + 3;
  localparam int TOTAL = NW * PER;
`ifdef MEM_WALK_WRITEBACK_EN
  localparam bit WB = 1'b1;
`else
  localparam bit WB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] mem_q;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [15:0] mem_d;
  logic [15:0] disp_value;
  logic        disp_valid;
  logic        busy;
  logic        done;

  mem_walk_fsm #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (10),
    .WORDS      (NW),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mem_q     (mem_q),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_d     (mem_d),
    .disp_value(disp_value),
    .disp_valid(disp_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Synchronous RAM, read-old-data.
  logic [15:0] ram [0:1023];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_d;
    mem_q <= ram[mem_addr];
  end

  typedef struct packed {
    logic [15:0] init;
    logic [15:0] w1;
    logic [15:0] w2;
  } vec_t;
  vec_t tbl [NW];

  logic [15:0] exp_ram [0:NW];
  logic [15:0] prev_disp;
  bit          in_done;
  logic [15:0] wq [$];
  logic [15:0] dq [$];
  int          checks = 0;
  int          failures = 0;
  int          da;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload(input logic [15:0] v0, input logic [15:0] v1,
                         input logic [15:0] v2, input logic [15:0] v3);
    ram[0] = v0; ram[1] = v1; ram[2] = v2; ram[3] = v3; ram[4] = 16'hBEEF;
    exp_ram[0] = v0; exp_ram[1] = v1; exp_ram[2] = v2; exp_ram[3] = v3;
    exp_ram[4] = 16'hBEEF;
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i <= NW; i++) chk({tag, "_ram"}, ram[i], exp_ram[i]);
  endtask

  // Cycles with start low while in IDLE (in_done=0) or DONE (in_done=1).
  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, in_done);
      chk("idle_valid", disp_valid, in_done);
      chk("idle_we", mem_we, 0);
      chk("idle_addr", 32'(mem_addr), in_done ? NW - 1 : 0);
      chk("idle_disp", disp_value, prev_disp);
      if (!WB || !in_done) chk("idle_memd", mem_d, 0);
    end
  endtask

  // One walk: start sampled at the next edge; p counts cycles from the first READ.
  // mode 0: start pulse, 1: start held high, 2: random start during the walk.
  task automatic run_walk(input int mode, input int abort_at, output int done_at);
    logic [15:0] raw [NW];
    logic [15:0] shown [NW];
    int w, ph;
    bit show;
    logic [15:0] ed;
    for (int i = 0; i < NW; i++) begin
      raw[i]   = exp_ram[i];
      shown[i] = WB ? raw[i] + 16'd1 : raw[i];
      if (WB) exp_ram[i] = shown[i];
    end
    wq.delete();
    dq.delete();
    done_at = -1;
    start = 1'b1;
    for (int p = 0; p <= TOTAL; p++) begin
      @(negedge clk);
      if (p < TOTAL) begin
        w  = p / PER;
        ph = p % PER;
      end else begin
        w  = NW - 1;
        ph = -1;
      end
      show = (p == TOTAL) || (ph >= 3);
      ed   = show ? shown[w] : ((w > 0) ? shown[w-1] : prev_disp);
      chk("busy", busy, p < TOTAL);
      chk("done", done, p == TOTAL);
      chk("disp_valid", disp_valid, show);
      chk("mem_we", mem_we, WB && (ph == 2));
      chk("mem_addr", 32'(mem_addr), w);
      chk("disp_value", disp_value, ed);
      if (!WB) chk("mem_d_zero", mem_d, 0);
      else if (ph == 2) chk("mem_d", mem_d, shown[w]);
      if (mem_we) wq.push_back(mem_d);
      if (ph == 3) dq.push_back(disp_value);
      if (done && done_at < 0) done_at = p;
      if (p == abort_at) begin
        rst = 1'b1;
        break;
      end
      case (mode)
        0: start = 1'b0;
        1: start = 1'b1;
        default: start = 1'($urandom_range(0, 1));
      endcase
      if (p == TOTAL && mode != 1) start = 1'b0;
    end
    prev_disp = shown[NW-1];
    in_done = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    if (WB) begin
      tbl[0] = '{init: 16'h0000, w1: 16'h0001, w2: 16'h0002};
      tbl[1] = '{init: 16'h00FF, w1: 16'h0100, w2: 16'h0101};
      tbl[2] = '{init: 16'hFFFF, w1: 16'h0000, w2: 16'h0001};
      tbl[3] = '{init: 16'h1234, w1: 16'h1235, w2: 16'h1236};
    end else begin
      tbl[0] = '{init: 16'h0000, w1: 16'h0000, w2: 16'h0000};
      tbl[1] = '{init: 16'h00FF, w1: 16'h00FF, w2: 16'h00FF};
      tbl[2] = '{init: 16'hFFFF, w1: 16'hFFFF, w2: 16'hFFFF};
      tbl[3] = '{init: 16'h1234, w1: 16'h1234, w2: 16'h1234};
    end

    rst = 1'b1;
    start = 1'b0;
    preload(tbl[0].init, tbl[1].init, tbl[2].init, tbl[3].init);
    prev_disp = 16'h0000;
    in_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle_check(5);

    // First walk against the table.
    run_walk(0, -1, da);
    chk("done_latency", da, TOTAL);
    chk("n_writes_1", wq.size(), WB ? NW : 0);
    chk("n_shown_1", dq.size(), NW);
    for (int i = 0; i < NW; i++) begin
      if (WB && i < wq.size()) chk("tbl_wr_1", wq[i], tbl[i].w1);
      if (i < dq.size()) chk("tbl_disp_1", dq[i], tbl[i].w1);
    end
    idle_check(3);
    readback("walk1");
    for (int i = 0; i < NW; i++) chk("tbl_ram_1", ram[i], tbl[i].w1);

    // Restart from DONE.
    run_walk(0, -1, da);
    chk("n_writes_2", wq.size(), WB ? NW : 0);
    chk("n_shown_2", dq.size(), NW);
    for (int i = 0; i < NW; i++) begin
      if (WB && i < wq.size()) chk("tbl_wr_2", wq[i], tbl[i].w2);
      if (i < dq.size()) chk("tbl_disp_2", dq[i], tbl[i].w2);
    end
    idle_check(2);
    readback("walk2");

    // start held high: no mid-walk restart, restart straight out of DONE.
    run_walk(1, -1, da);
    chk("n_writes_held", wq.size(), WB ? NW : 0);
    run_walk(0, -1, da);
    idle_check(2);
    readback("held");

    // Randomized RAM contents, gaps and start activity.
    for (int r = 0; r < 4; r++) begin
      preload(16'($urandom), (r == 0) ? 16'hFFFF : 16'($urandom), 16'($urandom),
              16'($urandom));
      idle_check($urandom_range(0, 4));
      run_walk(2, -1, da);
      chk("rand_done_latency", da, TOTAL);
      idle_check(1);
      readback("rand");
    end

    // Reset during the WRITE cycle of address 2.
    preload(tbl[0].init, tbl[1].init, tbl[2].init, tbl[3].init);
    run_walk(0, 2 * PER + 2, da);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    prev_disp = 16'h0000;
    in_done = 1'b0;
    chk("rst_we", mem_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", disp_valid, 0);
    chk("rst_disp", disp_value, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_memd", mem_d, 0);
    idle_check(3);
    chk("rst_ram2_single", (ram[2] == 16'hFFFF) || (WB && ram[2] == 16'h0000), 1);
    chk("rst_ram3", ram[3], 16'h1234);
    chk("rst_ram0", ram[0], tbl[0].w1);
    chk("rst_ram1", ram[1], tbl[1].w1);

    // Reset wins over start in the same cycle.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("rst_prio_busy", busy, 0);
    rst = 1'b0;
    start = 1'b0;
    idle_check(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
